osc_pulse_gen: RTL and testbench
================================

Name: osc_pulse_gen

Overview:
Programmable square-wave generator that emits an exact number of rising edges at a programmed half-period. It is the stimulus end of the edge-counting path: it drives known edge trains into the oscillator edge counter for calibration and self-test of the ring-oscillator measurement chain. Control is a start/abort/done handshake from the test sequencer.

Parameters:
CNT_W, 32, width of the edge-count request and the running edge count
HP_W, 16, width of the half-period value, in clk cycles

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
start  input  1  start request; sampled only in IDLE
abort  input  1  terminate the current run
half_period  input  HP_W  clk cycles per low phase and per high phase; 0 is treated as 1
num_edges  input  CNT_W  number of rising edges to emit
osc_out  output  1  generated square wave
busy  output  1  run in progress
done  output  1  one-cycle pulse when a run completes normally
edges_sent  output  CNT_W  rising edges emitted in the current or last run

Behaviour:
- Reset (asynchronous): osc_out=0, busy=0, done=0, edges_sent=0, state=IDLE, phase counter=0.
- States: IDLE, LOW, HIGH, FIN.
- IDLE, start=1, abort=0:
  - Latch hp=max(half_period,1) and N=num_edges; clear edges_sent.
  - If N=0: go to FIN. done=1 on the next cycle; busy stays 0.
  - Else: go to LOW with phase counter=hp-1 and busy=1 from the next cycle.
- LOW: osc_out=0. Phase counter decrements each cycle. At 0, go to HIGH, reload hp-1, and increment edges_sent in the same cycle osc_out rises.
- HIGH: osc_out=1. Phase counter decrements each cycle. At 0:
  - If edges_sent==N, go to FIN.
  - Else go to LOW and reload hp-1.
- FIN: osc_out=0, busy=0, done=1 for exactly one cycle, then IDLE.
- Timing: with start accepted at edge k, osc_out is low for cycles k+1..k+hp and high for k+hp+1..k+2hp, repeating. done is high at cycle k+2*hp*N+1. Total run is 2*hp*N cycles of busy.
- Input latching: half_period and num_edges are sampled only when start is accepted. Changes during a run are ignored.
- start while busy or in FIN: ignored, no queuing.
- abort in LOW/HIGH/FIN:
  - Next cycle: IDLE, osc_out=0, busy=0, done=0.
  - edges_sent holds its value.
  - A done pulse already scheduled in FIN is suppressed.
- abort and start together in IDLE: abort wins; start is ignored.
- No overflow: edges_sent never exceeds N and is CNT_W wide.
- Every output is registered; no combinational path from input to output.

Optional Feature:
OSC_JITTER_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clk cycle.
  - Each phase reload uses hp-1+lfsr[0], so each phase lasts hp or hp+1 cycles.
  - Run length lies in [2*hp*N, 2*hp*N+2*N]; edge count is still exact.
- Undefined: no LFSR is instantiated and the timing is exactly as above.

Decomposition:
- Shared package/include osc_gen_pkg:
  - state encoding (IDLE/LOW/HIGH/FIN)
  - default CNT_W/HP_W
  - LFSR seed and tap constants
- One natural sub-module: lfsr16, a free-running LFSR with async reset, instantiated only under OSC_JITTER_EN.
- The FSM and the phase and edge counters stay in osc_pulse_gen.

Test Plan:
- Basic run: hp=4, N=3, 1-cycle start at k.
  - osc_out: 4 low / 4 high, three times.
  - Rising edges at k+5, k+13, k+21.
  - done only at k+25; edges_sent=3.
  - A downstream edge counter reads 3.
- Zero edges: N=0, hp=7, start.
  - done at k+1, busy never 1, osc_out stays 0, edges_sent=0.
- Zero half-period: hp=0, N=5.
  - osc_out toggles every cycle (treated as hp=1).
  - done at k+11; edges_sent=5.
- Abort mid-run: hp=10, N=100, abort one cycle after the 2nd rising edge.
  - Next cycle: osc_out=0, busy=0.
  - No done; edges_sent=2.
  - A start while busy earlier in the run had no effect.
- Async reset mid-run: rst pulsed between clk edges during HIGH.
  - osc_out, busy, done and edges_sent go to 0 immediately.
  - A later start runs normally.
- OSC_JITTER_EN defined: hp=8, N=50.
  - Exactly 50 rising edges.
  - done cycle offset in [801, 901].
  - Two back-to-back runs give different total lengths.

Source files
------------

// File: rtl/osc_gen_pkg.sv
// -----------------------------------------------------------------------------
// osc_gen_pkg
// Shared definitions for the oscillator pulse generator:
//   - osc_state_t : FSM state encoding (IDLE / LOW / HIGH / FIN)
//   - CNT_W_DEF   : default width of the edge-count request / running count
//   - HP_W_DEF    : default width of the half-period value (clk cycles)
//   - LFSR_SEED   : reset value of the jitter LFSR
//   - LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
// -----------------------------------------------------------------------------
package osc_gen_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int HP_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_FIN  = 2'd3
   } osc_state_t;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit Fibonacci LFSR used to jitter the phase lengths of
// osc_pulse_gen. Only built when OSC_JITTER_EN is defined; without that
// macro this file is intentionally empty so no dangling module exists.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset (loads LFSR_SEED)
//   rnd  out bit 0 of the LFSR register (registered)
// -----------------------------------------------------------------------------
`ifdef OSC_JITTER_EN
module lfsr16
   import osc_gen_pkg::*;
(
   input  logic clk,
   input  logic rst,
   output logic rnd
);

   logic [15:0] lfsr_q;
   logic        fb;

   // XOR of the tapped bits, shifted in at the bottom.
   assign fb  = ^(lfsr_q & LFSR_TAPS);
   assign rnd = lfsr_q[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0], fb};
      end
   end

endmodule
`endif

// File: rtl/osc_pulse_gen.sv
// -----------------------------------------------------------------------------
// osc_pulse_gen
// Programmable square-wave generator: emits exactly num_edges rising edges,
// each low and high phase lasting half_period clk cycles (0 treated as 1).
// Optional macro OSC_JITTER_EN: each phase lasts hp or hp+1 cycles, chosen
// by a free-running LFSR; the edge count stays exact.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous, active-high reset
//   start        in  start request, sampled only in IDLE
//   abort        in  terminate the current run (wins over start in IDLE)
//   half_period  in  [HP_W]  cycles per low phase and per high phase
//   num_edges    in  [CNT_W] rising edges to emit
//   osc_out      out generated square wave
//   busy         out run in progress
//   done         out one-cycle pulse on normal completion
//   edges_sent   out [CNT_W] rising edges emitted in current/last run
// All outputs are registered.
// Handshake: start is accepted on a clk edge where the FSM is IDLE, start=1
// and abort=0; busy rises the following cycle (unless num_edges=0), done
// pulses for exactly one cycle at the end; abort returns to IDLE next cycle.
// -----------------------------------------------------------------------------
module osc_pulse_gen
   import osc_gen_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int HP_W  = HP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [HP_W-1:0]  half_period,
   input  logic [CNT_W-1:0] num_edges,
   output logic             osc_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] edges_sent
);

   osc_state_t       state;
   logic [HP_W-1:0]  hp_q;
   logic [CNT_W-1:0] n_q;
   logic [HP_W-1:0]  phase_cnt;
   logic [HP_W-1:0]  hp_eff;
   logic [HP_W-1:0]  jit_add;
   logic             jit;

`ifdef OSC_JITTER_EN
   lfsr16 u_lfsr (
      .clk (clk),
      .rst (rst),
      .rnd (jit)
   );
`else
   assign jit = 1'b0;
`endif

   // Zero half-period behaves like one so every phase lasts at least a cycle.
   assign hp_eff  = (half_period == '0) ? HP_W'(1) : half_period;
   assign jit_add = {{(HP_W-1){1'b0}}, jit};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         hp_q       <= '0;
         n_q        <= '0;
         phase_cnt  <= '0;
         osc_out    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         edges_sent <= '0;
      end else if (abort && (state != ST_IDLE)) begin
         // edges_sent is left alone so the sequencer can see how far it got.
         state   <= ST_IDLE;
         osc_out <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               osc_out <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               if (start && !abort) begin
                  hp_q       <= hp_eff;
                  n_q        <= num_edges;
                  edges_sent <= '0;
                  if (num_edges == '0) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_LOW;
                     phase_cnt <= hp_eff - HP_W'(1) + jit_add;
                     busy      <= 1'b1;
                  end
               end
            end

            ST_LOW: begin
               if (phase_cnt == '0) begin
                  // Count the edge in the same cycle osc_out rises.
                  state      <= ST_HIGH;
                  osc_out    <= 1'b1;
                  phase_cnt  <= hp_q - HP_W'(1) + jit_add;
                  edges_sent <= edges_sent + CNT_W'(1);
               end else begin
                  phase_cnt <= phase_cnt - HP_W'(1);
               end
            end

            ST_HIGH: begin
               if (phase_cnt == '0) begin
                  osc_out <= 1'b0;
                  if (edges_sent == n_q) begin
                     state <= ST_FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= ST_LOW;
                     phase_cnt <= hp_q - HP_W'(1) + jit_add;
                  end
               end else begin
                  phase_cnt <= phase_cnt - HP_W'(1);
               end
            end

            ST_FIN: begin
               // done was raised on entry; drop it after exactly one cycle.
               state   <= ST_IDLE;
               osc_out <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end

            default: begin
               state   <= ST_IDLE;
               osc_out <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_osc_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_osc_pulse_gen
// Directed bench for osc_pulse_gen. Cycle numbering: with start accepted at
// clk edge k, "cycle c" is the value sampled 1 time unit after edge k+c-1,
// so cycle 1 is the first cycle after acceptance.
// -----------------------------------------------------------------------------
module tb_osc_pulse_gen;

   localparam int CNT_W = 32;
   localparam int HP_W  = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic             abort;
   logic [HP_W-1:0]  half_period;
   logic [CNT_W-1:0] num_edges;
   logic             osc_out;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] edges_sent;

   int n_cmp = 0;
   int n_bad = 0;

   osc_pulse_gen #(.CNT_W(CNT_W), .HP_W(HP_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .half_period (half_period),
      .num_edges   (num_edges),
      .osc_out     (osc_out),
      .busy        (busy),
      .done        (done),
      .edges_sent  (edges_sent)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input longint act,
                              input longint lo, input longint hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // ---------------- driver: one full run ----------------
   task automatic run_case(input int hp, input int n, input int exp_done,
                           input int exp_edges, input string tag,
                           output int run_len);
      int     hp_eff;
      int     c;
      int     done_cyc;
      int     done_cnt;
      int     rises;
      int     wave_err;
      int     budget;
      logic   prev;
      logic   exp_osc;
      logic   exp_busy;
      hp_eff   = (hp == 0) ? 1 : hp;
      budget   = exp_done + 2 * n + 40;
      done_cyc = 0;
      done_cnt = 0;
      rises    = 0;
      wave_err = 0;
      prev     = 1'b0;
      exp_osc  = 1'b0;
      exp_busy = 1'b0;
      @(negedge clk);
      half_period = HP_W'(hp);
      num_edges   = CNT_W'(n);
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      // Inputs change mid-run; the latched values must be used.
      half_period = HP_W'($urandom_range(0, 20));
      num_edges   = CNT_W'($urandom_range(0, 9));
      c = 1;
      while (c <= budget) begin
         if (osc_out && !prev) rises++;
         prev = osc_out;
`ifndef OSC_JITTER_EN
         exp_busy = (c <= 2 * hp_eff * n);
         exp_osc  = exp_busy && ((((c - 1) / hp_eff) % 2) == 1);
         if (osc_out !== exp_osc || busy !== exp_busy) wave_err++;
`endif
         if (done) begin
            done_cnt++;
            if (done_cyc == 0) done_cyc = c;
         end
         if (done_cyc != 0 && c == done_cyc + 1) break;
         // A start while busy must be ignored.
         start = busy && (c == 3);
         @(posedge clk);
         #1;
         c++;
      end
      start = 1'b0;
      run_len = done_cyc;
`ifdef OSC_JITTER_EN
      if (n == 0) check({tag, "_done_cycle"}, done_cyc, exp_done);
      else check_range({tag, "_done_cycle"}, done_cyc, exp_done, exp_done + 2 * n);
`else
      check({tag, "_done_cycle"}, done_cyc, exp_done);
      check({tag, "_wave"}, wave_err, 0);
`endif
      check({tag, "_done_pulses"}, done_cnt, 1);
      check({tag, "_rises"}, rises, exp_edges);
      check({tag, "_edges_sent"}, edges_sent, exp_edges);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int hp;
      int n;
      int exp_done;
      int exp_edges;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int c;
      int rises;
      int seen;
      int len_a;
      int len_b;
      logic prev;

      vecs[0] = '{hp: 4, n: 3, exp_done: 25, exp_edges: 3};
      vecs[1] = '{hp: 0, n: 5, exp_done: 11, exp_edges: 5};
      vecs[2] = '{hp: 7, n: 0, exp_done:  1, exp_edges: 0};
      vecs[3] = '{hp: 1, n: 1, exp_done:  3, exp_edges: 1};
      vecs[4] = '{hp: 3, n: 2, exp_done: 13, exp_edges: 2};
      vecs[5] = '{hp: 2, n: 4, exp_done: 17, exp_edges: 4};

      rst         = 1'b1;
      start       = 1'b0;
      abort       = 1'b0;
      half_period = '0;
      num_edges   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_osc_out", osc_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_edges_sent", edges_sent, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run_case(vecs[i].hp, vecs[i].n, vecs[i].exp_done, vecs[i].exp_edges,
                  $sformatf("vec%0d", i), len_a);
         repeat (2) @(negedge clk);
      end

      // ---- abort one cycle after the 2nd rising edge ----
      @(negedge clk);
      half_period = 16'd10;
      num_edges   = 32'd100;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c = 1;
      rises = 0;
      prev = 1'b0;
      while (c < 200) begin
         if (osc_out && !prev) rises++;
         prev = osc_out;
         if (rises == 2) break;
         start = (c == 5);
         @(posedge clk);
         #1;
         c++;
      end
      start = 1'b0;
      check("abort_rises_before", rises, 2);
`ifndef OSC_JITTER_EN
      check("abort_second_rise_cycle", c, 31);
`endif
      @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check("abort_osc_out", osc_out, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_edges_sent", edges_sent, 2);
      seen = 0;
      repeat (250) begin
         @(posedge clk);
         #1;
         if (done || busy || osc_out) seen++;
      end
      check("abort_quiet_after", seen, 0);
      check("abort_edges_hold", edges_sent, 2);

      // ---- abort and start together in IDLE ----
      @(negedge clk);
      half_period = 16'd3;
      num_edges   = 32'd2;
      start       = 1'b1;
      abort       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      seen = 0;
      repeat (20) begin
         if (done || busy || osc_out) seen++;
         @(posedge clk);
         #1;
      end
      check("abort_start_idle_quiet", seen, 0);
      check("abort_start_idle_edges", edges_sent, 2);

      // ---- asynchronous reset during HIGH ----
      @(negedge clk);
      half_period = 16'd5;
      num_edges   = 32'd10;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c = 0;
      while (!osc_out && c < 100) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("arst_reached_high", osc_out, 1);
      check("arst_edges_before", edges_sent, 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_osc_out", osc_out, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_edges_sent", edges_sent, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      run_case(2, 3, 13, 3, "post_arst", len_a);

`ifdef OSC_JITTER_EN
      repeat (2) @(negedge clk);
      run_case(8, 50, 801, 50, "jit_a", len_a);
      repeat (2) @(negedge clk);
      run_case(8, 50, 801, 50, "jit_b", len_b);
      check("jit_lengths_differ", (len_a != len_b) ? 1 : 0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
